// File: rtl/ql_io_deserializer.sv
// ql_io_deserializer: serial-to-parallel capture behind the IOFF, with valid/ready output,
// bitslip alignment and a sticky overflow flag.
module ql_io_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             CK,
    input  logic             R,
    input  logic             D,
    input  logic             EN,
    input  logic             BITSLIP,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    input  logic             Q_READY,
    output logic             OVERFLOW,
    input  logic             CLR_OVF,
    output logic             SLIP_BUSY
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SLIP, LOCK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d, word_lsb, word;
    logic             valid_q, valid_d, ovf_q, ovf_d, bs_q;
    logic             slip, done, load;

    always_comb begin
        slip     = EN && state_q == SLIP;
        // A slip edge never completes a word: holding CNT pushes the boundary back one bit.
        done     = EN && !slip && cnt_q == CW'(WIDTH - 1);
        word_lsb = {D, sr_q};
        for (int i = 0; i < WIDTH; i++)
            word[i] = MSB_FIRST ? word_lsb[WIDTH-1-i] : word_lsb[i];
        load     = done && (!valid_q || Q_READY);
        sr_d     = EN ? word_lsb[WIDTH-1:1] : sr_q;
        cnt_d    = (!EN || slip) ? cnt_q : done ? '0 : cnt_q + 1'b1;
        q_d      = load ? word : q_q;
        valid_d  = load || (valid_q && !Q_READY);
        ovf_d    = (done && !load) || (ovf_q && !CLR_OVF);
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = (BITSLIP && !bs_q) ? SLIP : IDLE;
            SLIP:    state_d = EN ? LOCK : SLIP;
            LOCK:    state_d = done ? IDLE : LOCK;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            bs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            bs_q    <= BITSLIP;
        end
    end

    assign Q         = q_q;
    assign Q_VALID   = valid_q;
    assign OVERFLOW  = ovf_q;
    assign SLIP_BUSY = state_q != IDLE;
endmodule

// File: tb/tb_ql_io_deserializer.sv
// tb_ql_io_deserializer: directed vector table plus hand sequences for EN gating and reset,
// run on an LSB-first and an MSB-first instance fed the same stream.
module tb_ql_io_deserializer;
    logic       CK = 1'b0, R = 1'b1, D = 1'b0, EN = 1'b0, BITSLIP = 1'b0, Q_READY = 1'b0, CLR_OVF = 1'b0;
    logic [3:0] q_l, q_m;
    logic       v_l, v_m, ovf_l, ovf_m, busy_l, busy_m;
    int         n_vec = 0, n_err = 0;

    always #5 CK = ~CK;

    ql_io_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .CK(CK), .R(R), .D(D), .EN(EN), .BITSLIP(BITSLIP), .Q(q_l), .Q_VALID(v_l),
        .Q_READY(Q_READY), .OVERFLOW(ovf_l), .CLR_OVF(CLR_OVF), .SLIP_BUSY(busy_l));

    ql_io_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .CK(CK), .R(R), .D(D), .EN(EN), .BITSLIP(BITSLIP), .Q(q_m), .Q_VALID(v_m),
        .Q_READY(Q_READY), .OVERFLOW(ovf_m), .CLR_OVF(CLR_OVF), .SLIP_BUSY(busy_m));

    typedef struct {
        logic       d, en, bs, rdy, clr;
        logic [3:0] ql, qm;
        logic       v, ovf, busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [3:0] ql, input logic [3:0] qm,
                           input logic v, input logic ovf, input logic busy);
        chk("q_lsb", idx, q_l, ql);
        chk("q_msb", idx, q_m, qm);
        chk("valid", idx, {3'b0, v_l & v_m}, {3'b0, v});
        chk("valid_or", idx, {3'b0, v_l | v_m}, {3'b0, v});
        chk("ovf", idx, {2'b0, ovf_l, ovf_m}, {2'b0, ovf, ovf});
        chk("busy", idx, {2'b0, busy_l, busy_m}, {2'b0, busy, busy});
    endtask

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic add(input logic d, en, bs, rdy, clr, input logic [3:0] ql, qm, input logic v, ovf, busy);
        tbl.push_back('{d, en, bs, rdy, clr, ql, qm, v, ovf, busy});
    endtask

    initial begin
        logic [3:0] bits;
        //   d  en bs rdy clr  qlsb   qmsb   v  ovf busy
        add(1, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 4'h0, 4'h0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 4'hD, 4'hB, 1, 0, 0);
        add(1, 1, 0, 1, 0, 4'hD, 4'hB, 0, 0, 0);
        add(0, 1, 0, 0, 0, 4'hD, 4'hB, 0, 0, 0);
        add(1, 1, 0, 0, 0, 4'hD, 4'hB, 0, 0, 0);
        add(1, 1, 0, 0, 0, 4'hD, 4'hB, 1, 0, 0);
        add(1, 1, 0, 0, 0, 4'hD, 4'hB, 1, 0, 0);
        add(1, 1, 0, 0, 0, 4'hD, 4'hB, 1, 0, 0);
        add(0, 1, 0, 0, 0, 4'hD, 4'hB, 1, 0, 0);
        add(0, 1, 0, 0, 1, 4'hD, 4'hB, 1, 1, 0);
        add(0, 0, 0, 0, 1, 4'hD, 4'hB, 1, 0, 0);
        add(0, 0, 0, 1, 0, 4'hD, 4'hB, 0, 0, 0);
        add(1, 1, 0, 0, 0, 4'hD, 4'hB, 0, 0, 0);
        add(0, 1, 0, 0, 0, 4'hD, 4'hB, 0, 0, 0);
        add(0, 1, 0, 0, 0, 4'hD, 4'hB, 0, 0, 0);
        add(0, 1, 0, 0, 0, 4'h1, 4'h8, 1, 0, 0);
        add(0, 1, 0, 0, 0, 4'h1, 4'h8, 1, 0, 0);
        add(1, 1, 0, 0, 0, 4'h1, 4'h8, 1, 0, 0);
        add(0, 1, 0, 0, 0, 4'h1, 4'h8, 1, 0, 0);
        add(0, 1, 0, 1, 0, 4'h2, 4'h4, 1, 0, 0);
        add(1, 1, 1, 1, 0, 4'h2, 4'h4, 0, 0, 1);
        add(0, 1, 0, 1, 0, 4'h2, 4'h4, 0, 0, 1);
        add(0, 1, 1, 1, 0, 4'h2, 4'h4, 0, 0, 1);
        add(0, 1, 0, 1, 0, 4'h2, 4'h4, 0, 0, 1);
        add(1, 1, 0, 1, 0, 4'h8, 4'h1, 1, 0, 0);
        add(0, 1, 0, 1, 0, 4'h8, 4'h1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 4'h8, 4'h1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 4'h8, 4'h1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 4'h8, 4'h1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 4'h8, 4'h1, 0, 0, 0);

        #1;
        chk_all(-1, 4'h0, 4'h0, 0, 0, 0);
        tick;
        tick;
        R = 1'b0;
        tick;
        chk_all(0, 4'h0, 4'h0, 0, 0, 0);

        foreach (tbl[i]) begin
            D = tbl[i].d; EN = tbl[i].en; BITSLIP = tbl[i].bs; Q_READY = tbl[i].rdy; CLR_OVF = tbl[i].clr;
            tick;
            chk_all(i + 1, tbl[i].ql, tbl[i].qm, tbl[i].v, tbl[i].ovf, tbl[i].busy);
        end

        // EN alternating; the junk D on disabled edges must never enter the word.
        bits = 4'b0110;
        Q_READY = 1'b0; BITSLIP = 1'b0; CLR_OVF = 1'b0;
        for (int i = 0; i < 4; i++) begin
            EN = 1'b1; D = bits[i];
            tick;
            chk_all(100 + 2 * i, (i == 3) ? 4'h6 : 4'h8, (i == 3) ? 4'h6 : 4'h1, i == 3, 0, 0);
            EN = 1'b0; D = 1'b1;
            tick;
            chk_all(101 + 2 * i, (i == 3) ? 4'h6 : 4'h8, (i == 3) ? 4'h6 : 4'h1, i == 3, 0, 0);
        end

        // Pending slip and a partial word, then asynchronous reset between edges.
        BITSLIP = 1'b1;
        tick;
        chk_all(200, 4'h6, 4'h6, 1, 0, 1);
        BITSLIP = 1'b0; EN = 1'b1; D = 1'b0;
        tick;
        tick;
        chk_all(201, 4'h6, 4'h6, 1, 0, 1);
        #2 R = 1'b1;
        #1 chk_all(202, 4'h0, 4'h0, 0, 0, 0);
        #1 R = 1'b0;
        D = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk_all(203 + i, (i == 3) ? 4'hF : 4'h0, (i == 3) ? 4'hF : 4'h0, i == 3, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
